// File: rtl/interrupt_arbiter.sv
// Eight-line edge-triggered interrupt arbiter with memory-mapped mask/pending/status registers.
// Latency: input edge -> pending after 3 ph1 edges -> irq one edge later; register reads are combinational.
// Backpressure: one request is held until the core acks it or it is withdrawn; later edges queue in pending.
module interrupt_arbiter (
    input  logic        ph1,
    input  logic        reset,
    input  logic [7:0]  interrupts,
    input  logic        memwrite,
    input  logic [31:0] dataadr,
    input  logic [31:0] writedata,
    input  logic        irqack,
    input  logic        eret,
    output logic        irq,
    output logic [2:0]  irqcause,
    output logic [31:0] readdata
);

    localparam logic [31:0] ADR_MASK = 32'hFFFF_0000;
    localparam logic [31:0] ADR_PEND = 32'hFFFF_0004;
    localparam logic [31:0] ADR_STAT = 32'hFFFF_0008;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [7:0]  s1, s2, prev;
    logic [7:0]  mask, pending;
    logic [7:0]  rise, eligible, ack_clr, sw_clr;
    logic [2:0]  sel, cause_nxt;
    logic        wr_mask, wr_pend;
    logic        unused_wdata;

    assign unused_wdata = ^writedata[31:8];

    always_ff @(posedge ph1 or posedge reset) begin
        if (reset) begin
            s1   <= 8'h00;
            s2   <= 8'h00;
            prev <= 8'h00;
        end else begin
            s1   <= interrupts;
            s2   <= s1;
            prev <= s2;
        end
    end

    // prev resets low, so a line held high across reset counts as a fresh edge
    assign rise     = s2 & ~prev;
    assign eligible = pending & mask;
    assign wr_mask  = memwrite && (dataadr == ADR_MASK);
    assign wr_pend  = memwrite && (dataadr == ADR_PEND);
    assign sw_clr   = wr_pend ? writedata[7:0] : 8'h00;

    always_comb begin
        sel = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (eligible[i]) sel = 3'(i);
        end
    end

    always_comb begin
        state_nxt = state;
        cause_nxt = irqcause;
        ack_clr   = 8'h00;
        case (state)
            IDLE: begin
                if (|eligible) begin
                    state_nxt = REQ;
                    cause_nxt = sel;
                end
            end
            REQ: begin
                // ack takes precedence over a same-cycle withdrawal
                if (irqack) begin
                    state_nxt         = SERVICE;
                    ack_clr[irqcause] = 1'b1;
                end else if (!eligible[irqcause]) begin
                    state_nxt = IDLE;
                end
            end
            SERVICE: begin
                if (eret) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ph1 or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            irqcause <= 3'd0;
            mask     <= 8'h00;
            pending  <= 8'h00;
        end else begin
            state    <= state_nxt;
            irqcause <= cause_nxt;
            if (wr_mask) mask <= writedata[7:0];
            // a new edge wins over a clear of the same bit
            pending  <= (pending & ~(ack_clr | sw_clr)) | rise;
        end
    end

    assign irq = (state == REQ);

    always_comb begin
        readdata = 32'h0;
        case (dataadr)
            ADR_MASK: readdata = {24'h0, mask};
            ADR_PEND: readdata = {24'h0, pending};
            ADR_STAT: readdata = {27'h0, state, irqcause};
            default:  readdata = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_interrupt_arbiter.sv
// Directed bench for interrupt_arbiter: hand-computed expectations checked with immediate assertions.
module tb_interrupt_arbiter;

    logic        ph1 = 1'b0;
    logic        reset;
    logic [7:0]  interrupts;
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic        irqack;
    logic        eret;
    logic        irq;
    logic [2:0]  irqcause;
    logic [31:0] readdata;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] A_MASK = 32'hFFFF_0000;
    localparam logic [31:0] A_PEND = 32'hFFFF_0004;
    localparam logic [31:0] A_STAT = 32'hFFFF_0008;

    interrupt_arbiter dut (
        .ph1        (ph1),
        .reset      (reset),
        .interrupts (interrupts),
        .memwrite   (memwrite),
        .dataadr    (dataadr),
        .writedata  (writedata),
        .irqack     (irqack),
        .eret       (eret),
        .irq        (irq),
        .irqcause   (irqcause),
        .readdata   (readdata)
    );

    always #10 ph1 = ~ph1;

    task automatic tick();
        @(posedge ph1);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reg(input string tag, input logic [31:0] adr, input logic [31:0] exp);
        logic [31:0] d;
        dataadr = adr;
        #1;
        d = readdata;
        dataadr = 32'h0;
        chk(tag, d, exp);
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] dat);
        memwrite  = 1'b1;
        dataadr   = adr;
        writedata = dat;
        tick();
        memwrite  = 1'b0;
        dataadr   = 32'h0;
        writedata = 32'h0;
    endtask

    // holds lines high across two edges, then drops them
    task automatic pulse(input logic [7:0] lines);
        interrupts = lines;
        tick();
        tick();
        interrupts = 8'h00;
    endtask

    task automatic ack();
        irqack = 1'b1;
        tick();
        irqack = 1'b0;
    endtask

    task automatic do_eret();
        eret = 1'b1;
        tick();
        eret = 1'b0;
    endtask

    initial begin
        reset = 1'b1; interrupts = 8'h00; memwrite = 1'b0; dataadr = 32'h0;
        writedata = 32'h0; irqack = 1'b0; eret = 1'b0;
        tick(); tick();
        chk("rst_irq", {31'h0, irq}, 32'h0);
        chk("rst_cause", {29'h0, irqcause}, 32'h0);
        chk_reg("rst_mask", A_MASK, 32'h0);
        chk_reg("rst_pend", A_PEND, 32'h0);
        chk_reg("rst_stat", A_STAT, 32'h0);
        reset = 1'b0;
        tick();

        // single line 3, full latency and ack
        wr(A_MASK, 32'h0000_00FF);
        chk_reg("mask_ff", A_MASK, 32'hFF);
        irqack = 1'b1;
        do_eret();
        irqack = 1'b0;
        chk_reg("stray_ack_eret", A_STAT, 32'h0);
        pulse(8'h08);
        chk("l3_irq_k1", {31'h0, irq}, 32'h0);
        tick();
        chk_reg("l3_pend_k2", A_PEND, 32'h08);
        chk("l3_irq_k2", {31'h0, irq}, 32'h0);
        tick();
        chk("l3_irq_k3", {31'h0, irq}, 32'h1);
        chk("l3_cause", {29'h0, irqcause}, 32'h3);
        chk_reg("l3_stat_req", A_STAT, 32'h0B);
        ack();
        chk("l3_irq_ack", {31'h0, irq}, 32'h0);
        chk_reg("l3_pend_ack", A_PEND, 32'h00);
        chk_reg("l3_stat_svc", A_STAT, 32'h13);
        do_eret();
        chk_reg("l3_stat_idle", A_STAT, 32'h03);

        // lines 5 and 1 together: priority then remaining line after eret
        pulse(8'h22);
        tick(); tick();
        chk_reg("p51_pend", A_PEND, 32'h22);
        chk("p51_irq", {31'h0, irq}, 32'h1);
        chk("p51_cause1", {29'h0, irqcause}, 32'h1);
        ack();
        chk_reg("p51_pend_ack", A_PEND, 32'h20);
        do_eret();
        chk("p51_irq_eret", {31'h0, irq}, 32'h0);
        tick();
        chk("p51_irq_5", {31'h0, irq}, 32'h1);
        chk("p51_cause5", {29'h0, irqcause}, 32'h5);
        ack();

        // edge during service is queued, raised two edges after eret
        pulse(8'h04);
        tick(); tick();
        chk("svc_irq", {31'h0, irq}, 32'h0);
        chk_reg("svc_pend", A_PEND, 32'h04);
        chk_reg("svc_stat", A_STAT, 32'h15);
        do_eret();
        chk("svc_irq_e1", {31'h0, irq}, 32'h0);
        tick();
        chk("svc_irq_e2", {31'h0, irq}, 32'h1);
        chk("svc_cause2", {29'h0, irqcause}, 32'h2);
        ack();
        do_eret();

        // masked line 4; same-edge set and clear keeps the bit; unmask raises it
        wr(A_MASK, 32'h0000_0000);
        pulse(8'h10);
        memwrite = 1'b1; dataadr = A_PEND; writedata = 32'h10;
        tick();
        memwrite = 1'b0; dataadr = 32'h0; writedata = 32'h0;
        chk_reg("m4_setwins", A_PEND, 32'h10);
        tick();
        chk("m4_irq_masked", {31'h0, irq}, 32'h0);
        wr(A_MASK, 32'h0000_0010);
        tick();
        chk("m4_irq", {31'h0, irq}, 32'h1);
        chk("m4_cause", {29'h0, irqcause}, 32'h4);
        ack();
        do_eret();

        // software withdrawal of line 6 while requested
        wr(A_MASK, 32'h0000_00FF);
        pulse(8'h40);
        tick(); tick();
        chk("w6_irq", {31'h0, irq}, 32'h1);
        chk("w6_cause", {29'h0, irqcause}, 32'h6);
        wr(A_PEND, 32'h0000_0040);
        tick();
        chk("w6_irq_drop", {31'h0, irq}, 32'h0);
        chk_reg("w6_pend", A_PEND, 32'h00);
        chk_reg("w6_stat", A_STAT, 32'h06);

        // other addresses: no write effect, read zero
        wr(32'hFFFF_000C, 32'h0000_0000);
        chk_reg("oth_mask", A_MASK, 32'hFF);
        chk_reg("oth_read", 32'h0000_1234, 32'h0);

        // level-held line 7 is served once only
        interrupts = 8'h80;
        tick(); tick(); tick(); tick();
        chk("lvl_irq", {31'h0, irq}, 32'h1);
        chk("lvl_cause", {29'h0, irqcause}, 32'h7);
        ack();
        do_eret();
        tick(); tick(); tick();
        chk("lvl_irq_held", {31'h0, irq}, 32'h0);
        chk_reg("lvl_pend_held", A_PEND, 32'h00);
        interrupts = 8'h00;
        tick(); tick(); tick();

        // reset mid-request, then line already high at reset release
        pulse(8'h01);
        tick(); tick();
        chk("rr_irq", {31'h0, irq}, 32'h1);
        interrupts = 8'h02;
        reset = 1'b1;
        #1;
        chk("rr_irq_async", {31'h0, irq}, 32'h0);
        chk_reg("rr_mask", A_MASK, 32'h0);
        chk_reg("rr_pend", A_PEND, 32'h0);
        chk_reg("rr_stat", A_STAT, 32'h0);
        tick();
        reset = 1'b0;
        tick(); tick(); tick();
        chk_reg("rr_pend_edge", A_PEND, 32'h02);
        chk("rr_irq_masked", {31'h0, irq}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/interrupt_arbiter.md
INTERRUPT_ARBITER -- requirements
Module: interrupt_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Port: ph1  input  1  single clock; all state updates on posedge ph1.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: interrupts  input  8  external interrupt lines, asynchronous to ph1, level-high.
REQ-005 Port: memwrite  input  1  core store strobe, valid for one ph1 cycle.
REQ-006 Port: dataadr  input  32  core data address.
REQ-007 Port: writedata  input  32  core store data.
REQ-008 Port: irqack  input  1  core accepts the presented interrupt; one-cycle pulse.
REQ-009 Port: eret  input  1  core has left the handler; one-cycle pulse.
REQ-010 Port: irq  output  1  interrupt request to the core.
REQ-011 Port: irqcause  output  3  index of the requested line; valid while irq=1.
REQ-012 Port: readdata  output  32  combinational register read data.

Function
REQ-013 Each interrupts bit SHALL pass through a 2-flop synchronizer (s1, s2) followed by a history flop (prev).
REQ-014 A rising edge SHALL be detected when s2=1 and prev=0; that edge sets pending[i] at the next posedge.
REQ-015 Latency: line high before edge k -> pending[i]=1 after edge k+2 -> irq=1 after edge k+3 (arbiter idle, line enabled).
REQ-016 Level-held lines SHALL NOT re-set pending; a new low-to-high transition is required.
REQ-017 mask[7:0]: bit=1 enables line; write at dataadr 0xFFFF0000 with memwrite loads writedata[7:0].
REQ-018 Write at 0xFFFF0004 SHALL clear pending bits where writedata[7:0]=1 (write-1-to-clear).
REQ-019 Same-cycle set and clear of one pending bit: set wins.
REQ-020 eligible = pending & mask; selected = lowest eligible index (bit 0 highest priority).
REQ-021 FSM states: IDLE, REQ, SERVICE.
REQ-022 IDLE: eligible!=0 -> REQ at next edge; irqcause latched with the selected index.
REQ-023 REQ: irq=1; irqcause held constant (no preemption by higher-priority arrivals).
REQ-024 REQ with irqack=1 -> SERVICE; pending[irqcause] cleared on the same edge.
REQ-025 REQ with eligible[irqcause]=0 (masked or cleared by software) and irqack=0 -> IDLE; irq drops next cycle.
REQ-026 REQ with irqack=1 and withdrawal on the same edge: ack wins, -> SERVICE.
REQ-027 SERVICE: irq=0; new edges still set pending; eret=1 -> IDLE.
REQ-028 irqack outside REQ and eret outside SERVICE SHALL be ignored.
REQ-029 After eret, a remaining eligible line SHALL raise irq no earlier than 2 edges after the eret edge (IDLE, then REQ).
REQ-030 readdata: 0xFFFF0000 -> {24'b0, mask}; 0xFFFF0004 -> {24'b0, pending}; 0xFFFF0008 -> {27'b0, state[1:0], irqcause}; any other address -> 0.
REQ-031 State encoding: IDLE=0, REQ=1, SERVICE=2.
REQ-032 Writes to other addresses SHALL have no effect on the block.

Reset
REQ-033 Reset SHALL asynchronously force state=IDLE, irq=0, irqcause=0, mask=0x00, pending=0x00, and all synchronizer and prev flops to 0.
REQ-034 Reset asserted in REQ or SERVICE SHALL drop irq without waiting for a clock edge.
REQ-035 A line already high when reset deasserts SHALL register as a rising edge, since prev resets to 0.

Verification
REQ-036 mask=0xFF, pulse interrupts[3] for 2 cycles -> irq=1, irqcause=3 after edge k+3; irqack -> pending=0x00, irq=0.
REQ-037 Edges on lines 5 and 1 in the same cycle, mask=0xFF -> irqcause=1; after ack and eret -> irqcause=5.
REQ-038 In SERVICE, pulse interrupts[2] -> irq stays 0, pending[2]=1; eret -> irq=1, irqcause=2 two edges later.
REQ-039 mask=0x00, edge on line 4 -> pending=0x10, irq=0; write 0x10 to 0xFFFF0000 -> irq=1, irqcause=4.
REQ-040 In REQ on line 6, write 0x40 to 0xFFFF0004 with no ack -> state IDLE, irq=0, pending=0x00.
REQ-041 Assert reset mid-REQ -> irq=0 immediately; all registers read 0 after reset.
